// File: rtl/alu_issue_ctrl.sv
// Fetch/decode/execute/writeback sequencer that feeds an external ALU and retires into an 8x16 register file.
// Optional retire trace port is enabled with the ALU_ISSUE_TRACE_EN macro.
module alu_issue_ctrl #(
  parameter logic [15:0] RESET_IP = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] alu_opcode,
  output logic [15:0] alu_regA,
  output logic [15:0] alu_regB,
  output logic [15:0] alu_imm,
  output logic [15:0] alu_ip,
  input  logic [15:0] alu_res,
  input  logic [15:0] alu_next_ip,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_p,
  output logic [2:0]  nzp,
  output logic        halted,
  output logic        retire_valid,
  output logic [15:0] retire_ip,
  output logic [15:0] retire_wdata,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        started;
  logic [15:0] ip, ir;
  logic [15:0] regs [8];
  logic [15:0] res_q, nip_q;
  logic [2:0]  flags_q;
  logic [3:0]  op;
  logic [2:0]  src_b;
  logic        fetch_take;
  logic        wr_en, nzp_en, br_taken;
  logic [15:0] wr_data, ip_wb, br_off;

  assign op         = ir[15:12];
  assign src_b      = (op == 4'hB && ir[8]) ? ir[2:0] : ir[8:6];
  assign br_off     = {{7{ir[8]}}, ir[8:0]};
  assign br_taken   = |(ir[11:9] & nzp);
  // started keeps imem_req low until the first clock edge after reset release
  assign fetch_take = (state == S_FETCH) && started && imem_ack;
  assign imem_addr  = ip;
  assign alu_ip     = ip;
  assign fsm_state  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (fetch_take) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = (op == 4'hD) ? S_HALT : S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req = (state == S_FETCH) && started;
    halted   = (state == S_HALT);
  end

  // Writeback effects selected by the opcode held in IR
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    nzp_en  = 1'b0;
    ip_wb   = ip + 16'd1;
    case (op)
      4'hA: begin
        nzp_en = 1'b1;
        ip_wb  = nip_q;
      end
      4'hB: begin
        wr_en   = 1'b1;
        wr_data = ir[8] ? regs[ir[2:0]] : {8'h00, ir[7:0]};
        ip_wb   = nip_q;
      end
      4'hC: ip_wb = br_taken ? (ip + 16'd1 + br_off) : (ip + 16'd1);
      4'hD: ip_wb = ip;
      4'hE, 4'hF: ip_wb = ip + 16'd1;
      default: begin
        wr_en   = 1'b1;
        wr_data = res_q;
        nzp_en  = 1'b1;
        ip_wb   = nip_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started    <= 1'b0;
      ip         <= RESET_IP;
      ir         <= '0;
      nzp        <= 3'b010;
      alu_opcode <= '0;
      alu_regA   <= '0;
      alu_regB   <= '0;
      alu_imm    <= '0;
      res_q      <= '0;
      nip_q      <= '0;
      flags_q    <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      started <= 1'b1;
      case (state)
        S_FETCH: if (fetch_take) ir <= imem_rdata;
        S_DECODE: begin
          alu_opcode <= ir;
          alu_regA   <= regs[ir[11:9]];
          alu_regB   <= regs[src_b];
          alu_imm    <= {{11{ir[4]}}, ir[4:0]};
        end
        S_EXEC: begin
          res_q   <= alu_res;
          flags_q <= {alu_n, alu_z, alu_p};
          nip_q   <= alu_next_ip;
        end
        S_WB: begin
          ip <= ip_wb;
          if (wr_en)  regs[ir[11:9]] <= wr_data;
          if (nzp_en) nzp <= flags_q;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ISSUE_TRACE_EN
  assign retire_valid = (state == S_WB);
  assign retire_ip    = (state == S_WB) ? ip : 16'h0000;
  assign retire_wdata = (state == S_WB && wr_en) ? wr_data : 16'h0000;
`else
  assign retire_valid = 1'b0;
  assign retire_ip    = 16'h0000;
  assign retire_wdata = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: the bench plays instruction memory and ALU, keeps an
// architectural model, and scoreboards the operand latches presented in EXEC.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] alu_opcode, alu_regA, alu_regB, alu_imm, alu_ip;
  logic [15:0] alu_res = '0;
  logic [15:0] alu_next_ip = '0;
  logic        alu_n = 1'b0, alu_z = 1'b0, alu_p = 1'b0;
  logic [2:0]  nzp;
  logic        halted;
  logic        retire_valid;
  logic [15:0] retire_ip, retire_wdata;
  logic [2:0]  fsm_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // scoreboard entry: {opcode, regA, regB, imm, ip}
  logic [79:0] exp_q[$];
  logic [15:0] mr [8];
  logic [15:0] m_ip;
  logic [2:0]  m_nzp;
  logic        m_halt;

  alu_issue_ctrl #(.RESET_IP(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .alu_opcode(alu_opcode), .alu_regA(alu_regA), .alu_regB(alu_regB),
    .alu_imm(alu_imm), .alu_ip(alu_ip),
    .alu_res(alu_res), .alu_next_ip(alu_next_ip),
    .alu_n(alu_n), .alu_z(alu_z), .alu_p(alu_p),
    .nzp(nzp), .halted(halted),
    .retire_valid(retire_valid), .retire_ip(retire_ip), .retire_wdata(retire_wdata),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mr[i] = '0;
    m_ip = 16'h0000;
    m_nzp = 3'b010;
    m_halt = 1'b0;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_nzp", nzp, 3'b010);
    chk("rst_halted", halted, 1'b0);
    chk("rst_state", fsm_state, 3'd0);
    chk("rst_opcode", alu_opcode, 16'h0000);
    chk("rst_rega", alu_regA, 16'h0000);
    chk("rst_regb", alu_regB, 16'h0000);
    chk("rst_imm", alu_imm, 16'h0000);
    chk("rst_retire_valid", retire_valid, 1'b0);
    chk("rst_retire_ip", retire_ip, 16'h0000);
    chk("rst_retire_wdata", retire_wdata, 16'h0000);
  endtask

  // Issue one instruction word; res/fl are the ALU's answer, delay is cycles of late ack.
  task automatic issue(input logic [15:0] w, input logic [15:0] res, input logic [2:0] fl,
                       input int delay);
    logic [3:0]  op;
    logic [15:0] a, b, imm, wd, n_ip;
    logic [2:0]  n_nzp;
    logic [79:0] e;
    logic        we;
    int          n;
    n = 0;
    while (!imem_req && n < 30) begin
      step();
      n++;
    end
    chk("req_seen", imem_req, 1'b1);
    if (!imem_req) return;
    chk("imem_addr", imem_addr, m_ip);
    for (int i = 0; i < delay; i++) begin
      imem_rdata = 16'hD000 | 16'($urandom_range(0, 255));
      step();
      chk("req_hold", imem_req, 1'b1);
      chk("fetch_wait_state", fsm_state, 3'd0);
    end
    imem_rdata = w;
    imem_ack = 1'b1;
    op  = w[15:12];
    a   = mr[w[11:9]];
    b   = (op == 4'hB && w[8]) ? mr[w[2:0]] : mr[w[8:6]];
    imm = {{11{w[4]}}, w[4:0]};
    exp_q.push_back({w, a, b, imm, m_ip});
    step();
    imem_ack = 1'b0;
    imem_rdata = 16'($urandom_range(0, 65535));
    chk("decode_state", fsm_state, 3'd1);
    step();
    chk("sb_nonempty", 16'(exp_q.size()), 16'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("alu_opcode", alu_opcode, e[79:64]);
      chk("alu_regA", alu_regA, e[63:48]);
      chk("alu_regB", alu_regB, e[47:32]);
      chk("alu_imm", alu_imm, e[31:16]);
      chk("alu_ip", alu_ip, e[15:0]);
    end
    alu_res = res;
    {alu_n, alu_z, alu_p} = fl;
    alu_next_ip = (op <= 4'hB) ? m_ip + 16'd1 : 16'hDEAD;
    we = 1'b0;
    wd = '0;
    n_nzp = m_nzp;
    n_ip = m_ip + 16'd1;
    if (op <= 4'h9) begin
      we = 1'b1; wd = res; n_nzp = fl;
    end else if (op == 4'hA) begin
      n_nzp = fl;
    end else if (op == 4'hB) begin
      we = 1'b1; wd = w[8] ? mr[w[2:0]] : {8'h00, w[7:0]};
    end else if (op == 4'hC) begin
      if ((w[11:9] & m_nzp) != 3'b000) n_ip = m_ip + 16'd1 + {{7{w[8]}}, w[8:0]};
    end else if (op == 4'hD) begin
      n_ip = m_ip;
    end
    step();
    alu_res = 16'($urandom_range(0, 65535));
    alu_next_ip = 16'($urandom_range(0, 65535));
    {alu_n, alu_z, alu_p} = 3'($urandom_range(0, 7));
`ifdef ALU_ISSUE_TRACE_EN
    chk("retire_valid", retire_valid, 1'b1);
    chk("retire_ip", retire_ip, m_ip);
    chk("retire_wdata", retire_wdata, wd);
`else
    chk("retire_valid_off", retire_valid, 1'b0);
    chk("retire_wdata_off", retire_wdata, 16'h0000);
`endif
    step();
    if (we) mr[w[11:9]] = wd;
    m_nzp = n_nzp;
    m_ip = n_ip;
    m_halt = (op == 4'hD);
    chk("retire_pulse_end", retire_valid, 1'b0);
    chk("nzp", nzp, m_nzp);
    chk("halted", halted, m_halt);
    chk("next_req", imem_req, !m_halt);
    chk("next_ip", imem_addr, m_ip);
  endtask

  initial begin
    do_reset();
    step();
    chk("first_req", imem_req, 1'b1);

    issue(16'hB005, 16'h0000, 3'b000, 0);  // LD R0,#5
    chk("ld_ip", imem_addr, 16'h0001);
    chk("ld_nzp", nzp, 3'b010);
    issue(16'hB203, 16'h0000, 3'b000, 0);  // LD R1,#3
    issue(16'hB404, 16'h0000, 3'b000, 0);  // LD R2,#4
    issue(16'h0688, 16'h0007, 3'b001, 0);  // ADD R3 -> 7
    chk("add_nzp", nzp, 3'b001);
    issue(16'hB903, 16'h0000, 3'b000, 0);  // LD R4,R3 reads freshly written R3
    issue(16'h1900, 16'h8000, 3'b100, 0);
    issue(16'h2E1F, 16'h0000, 3'b010, 0);
    issue(16'hA000, 16'h1234, 3'b010, 0);  // CMP leaves R0 alone
    issue(16'hE000, 16'h0000, 3'b000, 0);
    issue(16'hA000, 16'h0000, 3'b100, 0);  // CMP n
    chk("cmp_ip", imem_addr, 16'd10);
    issue(16'hC9FE, 16'h0000, 3'b000, 0);  // BR n -2, taken
    chk("br_n_ip", imem_addr, 16'd9);
    issue(16'hE000, 16'h0000, 3'b000, 0);
    issue(16'hC5FE, 16'h0000, 3'b000, 0);  // BR z -2, not taken
    chk("br_z_ip", imem_addr, 16'd11);
    issue(16'hF000, 16'h0000, 3'b000, 3);  // late ack
    chk("late_ip", imem_addr, 16'd12);
    issue(16'hD000, 16'h0000, 3'b000, 0);  // HALT
    for (int i = 0; i < 8; i++) begin
      step();
      chk("halt_hold", halted, 1'b1);
      chk("halt_noreq", imem_req, 1'b0);
    end
    chk("halt_ip", imem_addr, 16'd12);

    do_reset();
    step();
    rst = 1'b1;
    #1;
    chk("midfetch_req_drop", imem_req, 1'b0);
    imem_rdata = 16'hD000;
    imem_ack = 1'b1;
    step();
    rst = 1'b0;
    chk("rel_req", imem_req, 1'b0);
    step();
    imem_ack = 1'b0;
    chk("stale_ack_ignored", fsm_state, 3'd0);
    chk("rel_addr", imem_addr, 16'h0000);

    issue(16'hC5FE, 16'h0000, 3'b000, 0);  // BR z to 0xFFFF
    chk("wrap_br_ip", imem_addr, 16'hFFFF);
    issue(16'h0688, 16'h0007, 3'b001, 0);  // ADD at 0xFFFF
    chk("wrap_add_ip", imem_addr, 16'h0000);
    issue(16'hC7FE, 16'h0000, 3'b000, 0);  // BR zp, taken on p
    issue(16'hE000, 16'h0000, 3'b000, 0);  // NOP wraps own increment
    chk("wrap_nop_ip", imem_addr, 16'h0000);
    issue(16'hC000, 16'h0000, 3'b000, 0);  // empty mask never branches
    chk("br_none_ip", imem_addr, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
